// File: rtl/display_scan.sv
// rtl/display_scan.sv - 4-digit 7-segment scanner with per-slot dead-time and per-frame value snapshot
// Optional LEADING_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown).
module display_scan #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] num,
    output logic [1:0]  digit,
    output logic [3:0]  hex,
    output logic        blank,
    output logic        frame_start
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    // With no dead-time a slot opens directly in SHOW.
    localparam state_t SLOT_ENTRY = (BLANK_CYC == 0) ? SHOW : DEAD;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    digit_nx;
    logic [15:0]   num_q;
    logic          snap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            digit       <= 2'd0;
            num_q       <= 16'h0000;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            digit       <= digit_nx;
            frame_start <= snap;
            if (snap) begin
                num_q <= num;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        digit_nx = digit;
        snap     = 1'b0;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            digit_nx = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = SLOT_ENTRY;
                    cnt_nx   = '0;
                    digit_nx = 2'd0;
                    snap     = 1'b1;
                end
                DEAD: begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == BLANK_LAST) begin
                        state_nx = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        digit_nx = digit + 2'd1;
                        state_nx = SLOT_ENTRY;
                        // Leaving digit 3 starts a new frame: take a fresh snapshot.
                        snap     = (digit == 2'd3);
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    digit_nx = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        hex   = num_q[{digit, 2'b00} +: 4];
        blank = (state != SHOW);
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit != 2'd0) && ((num_q >> {digit, 2'b00}) == 16'h0000)) begin
            blank = 1'b1;
        end
`endif
    end

endmodule
